// File: rtl/seg7_mux_driver.sv
// seg7_mux_driver: time-multiplexed driver for a NUM_DIGITS seven-segment
// display. A load strobe captures a packed hex word into a shadow register;
// a prescaler advances the scanned digit every REFRESH_DIV enabled cycles and
// all pin-level outputs are registered.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks the segments of
// non-zero-index digits whose value and all higher digits are zero.
module seg7_mux_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 100000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1,
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int PS_W  = $clog2(REFRESH_DIV)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [IDX_W-1:0]        digit_idx
);

  // Pin levels that leave the display dark.
  localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF  = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_ACTIVE_LOW != 0}};

  // Hex nibble to active-high segment pattern, bit order g..a.
  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'h3F;
      4'h1:    pat = 7'h06;
      4'h2:    pat = 7'h5B;
      4'h3:    pat = 7'h4F;
      4'h4:    pat = 7'h66;
      4'h5:    pat = 7'h6D;
      4'h6:    pat = 7'h7D;
      4'h7:    pat = 7'h07;
      4'h8:    pat = 7'h7F;
      4'h9:    pat = 7'h6F;
      4'hA:    pat = 7'h77;
      4'hB:    pat = 7'h7C;
      4'hC:    pat = 7'h39;
      4'hD:    pat = 7'h5E;
      4'hE:    pat = 7'h79;
      4'hF:    pat = 7'h71;
      default: pat = 7'h00;
    endcase
    return pat;
  endfunction

  logic [PS_W-1:0]           r_ps;
  logic [IDX_W-1:0]          r_idx;
  logic [4*NUM_DIGITS-1:0]   r_shadow;
  logic [NUM_DIGITS-1:0]     r_dp;

  logic                      w_tick;
  logic [IDX_W-1:0]          w_idx_next;
  logic [NUM_DIGITS-1:0]     w_an_on;
  logic [3:0]                w_nib;
  logic                      w_dp_on;
  logic                      w_blank;
  logic [6:0]                w_seg_on;
  logic [6:0]                w_seg_nxt;
  logic                      w_dp_nxt;
  logic [NUM_DIGITS-1:0]     w_an_nxt;

  // Prescaler terminal count and digit index successor.
  always_comb begin
    w_tick     = (r_ps == PS_W'(REFRESH_DIV - 1));
    w_idx_next = '0;
    if (r_idx == IDX_W'(NUM_DIGITS - 1)) begin
      w_idx_next = '0;
    end else begin
      w_idx_next = r_idx + IDX_W'(1);
    end
  end

  // Prescaler and scan index advance only while enabled; both hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ps  <= '0;
      r_idx <= '0;
    end else if (enable) begin
      if (w_tick) begin
        r_ps  <= '0;
        r_idx <= w_idx_next;
      end else begin
        r_ps  <= r_ps + PS_W'(1);
      end
    end else begin
      r_ps  <= r_ps;
      r_idx <= r_idx;
    end
  end

  // Shadow copy of the displayed word, captured on the load strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow <= '0;
      r_dp     <= '0;
    end else if (load) begin
      r_shadow <= data_in;
      r_dp     <= dp_in;
    end else begin
      r_shadow <= r_shadow;
      r_dp     <= r_dp;
    end
  end

  // Select the current digit's nibble and dp with an AND-OR mux on one-hot idx.
  always_comb begin
    w_an_on = '0;
    w_nib   = 4'h0;
    w_dp_on = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_an_on[i] = (r_idx == IDX_W'(i));
      w_nib      = w_nib | (r_shadow[4*i +: 4] & {4{w_an_on[i]}});
      w_dp_on    = w_dp_on | (r_dp[i] & w_an_on[i]);
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] w_zero_from;
  logic                  v_all_zero;

  // Digit i is a leading zero when it and every higher digit are zero; digit 0 never blanks.
  always_comb begin
    w_zero_from = '0;
    v_all_zero  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      v_all_zero     = v_all_zero & (r_shadow[4*i +: 4] == 4'h0);
      w_zero_from[i] = v_all_zero;
    end
    w_blank = ((w_zero_from & w_an_on & ~NUM_DIGITS'(1)) != '0);
  end
`else
  // Every digit is always decoded.
  always_comb begin
    w_blank = 1'b0;
  end
`endif

  // Decode and apply pin polarity for the next output values.
  always_comb begin
    w_seg_on = hex_decode(w_nib);
    if (w_blank) begin
      w_seg_on = 7'h00;
    end else begin
      w_seg_on = hex_decode(w_nib);
    end
    if (SEG_ACTIVE_LOW != 0) begin
      w_seg_nxt = ~w_seg_on;
      w_dp_nxt  = ~w_dp_on;
    end else begin
      w_seg_nxt = w_seg_on;
      w_dp_nxt  = w_dp_on;
    end
    if (AN_ACTIVE_LOW != 0) begin
      w_an_nxt = ~w_an_on;
    end else begin
      w_an_nxt = w_an_on;
    end
  end

  // Registered pin outputs: dark in reset or while disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg       <= SEG_OFF;
      dp        <= DP_OFF;
      an        <= AN_OFF;
      digit_idx <= '0;
    end else if (enable) begin
      seg       <= w_seg_nxt;
      dp        <= w_dp_nxt;
      an        <= w_an_nxt;
      digit_idx <= r_idx;
    end else begin
      seg       <= SEG_OFF;
      dp        <= DP_OFF;
      an        <= AN_OFF;
      digit_idx <= r_idx;
    end
  end

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Testbench for seg7_mux_driver: 4 digits, REFRESH_DIV=4, active-low pins.
// Fixed vector table, directed corner sequences and random stimulus, all
// checked against a reference model that derives the scan position from the
// number of enabled cycles since reset.
module tb_seg7_mux_driver;
  localparam int N   = 4;
  localparam int DIV = 4;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        load;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [1:0]  digit_idx;

  int nchk;
  int nerr;

  // Reference model state
  int          m_cnt;
  logic [15:0] m_shadow;
  logic [3:0]  m_dp;
  logic [6:0]  dec_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  typedef struct {
    logic        r;
    logic        en;
    logic        ld;
    logic [15:0] di;
    logic [3:0]  dpi;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
  } vec_t;
  vec_t vt [13];

  seg7_mux_driver #(
    .NUM_DIGITS(N), .REFRESH_DIV(DIV), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .load(load),
    .data_in(data_in), .dp_in(dp_in),
    .seg(seg), .dp(dp), .an(an), .digit_idx(digit_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: drive inputs, predict outputs from pre-edge model state, advance model, compare.
  task automatic step(input logic r, input logic en, input logic ld,
                      input logic [15:0] di, input logic [3:0] dpi, input string nm);
    int         idx;
    logic [3:0] nib;
    logic       blank;
    logic [6:0] es;
    logic       ed;
    logic [3:0] ea;
    int         ei;
    rst = r; enable = en; load = ld; data_in = di; dp_in = dpi;
    idx = (m_cnt / DIV) % N;
    ei  = idx;
    if (r || !en) begin
      es = 7'h7F; ed = 1'b1; ea = 4'hF;
      if (r) ei = 0;
    end else begin
      nib   = 4'((m_shadow >> (4 * idx)) & 16'h000F);
      blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      blank = (idx > 0) && ((m_shadow >> (4 * idx)) == 16'h0000);
`endif
      es = blank ? 7'h7F : ~dec_tab[nib];
      ed = ~m_dp[idx];
      ea = ~(4'b0001 << idx);
    end
    @(posedge clk);
    if (r) begin
      m_cnt = 0; m_shadow = 16'h0000; m_dp = 4'h0;
    end else begin
      if (en) m_cnt = m_cnt + 1;
      if (ld) begin
        m_shadow = di; m_dp = dpi;
      end
    end
    #1;
    nchk = nchk + 1;
    if (seg !== es || dp !== ed || an !== ea || ((r || en) && digit_idx !== 2'(ei))) begin
      nerr = nerr + 1;
      $display("FAIL %s: got seg=%h dp=%b an=%h idx=%0d, expected seg=%h dp=%b an=%h idx=%0d",
               nm, seg, dp, an, digit_idx, es, ed, ea, ei);
    end
  endtask

  // Compare current outputs against fixed constants.
  task automatic check_const(input logic [6:0] es, input logic ed, input logic [3:0] ea,
                             input string nm);
    nchk = nchk + 1;
    if (seg !== es || dp !== ed || an !== ea) begin
      nerr = nerr + 1;
      $display("FAIL %s: got seg=%h dp=%b an=%h, expected seg=%h dp=%b an=%h",
               nm, seg, dp, an, es, ed, ea);
    end
  endtask

  initial begin
    nchk = 0; nerr = 0;
    m_cnt = 0; m_shadow = 16'h0000; m_dp = 4'h0;
    rst = 1'b1; enable = 1'b0; load = 1'b0; data_in = 16'h0000; dp_in = 4'h0;

    vt[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 4'h0, 7'h7F, 1'b1, 4'hF};
    vt[1]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 4'h0, 7'h7F, 1'b1, 4'hF};
    vt[2]  = '{1'b0, 1'b1, 1'b1, 16'h1234, 4'h4, 7'h40, 1'b1, 4'hE};
    vt[3]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 4'h0, 7'h19, 1'b1, 4'hE};
    vt[4]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 4'h0, 7'h19, 1'b1, 4'hE};
    vt[5]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 4'h0, 7'h19, 1'b1, 4'hE};
    vt[6]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 4'h0, 7'h30, 1'b1, 4'hD};
    vt[7]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 4'h0, 7'h30, 1'b1, 4'hD};
    vt[8]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 4'h0, 7'h30, 1'b1, 4'hD};
    vt[9]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 4'h0, 7'h30, 1'b1, 4'hD};
    vt[10] = '{1'b0, 1'b1, 1'b0, 16'h0000, 4'h0, 7'h24, 1'b0, 4'hB};
    vt[11] = '{1'b0, 1'b0, 1'b0, 16'h0000, 4'h0, 7'h7F, 1'b1, 4'hF};
    vt[12] = '{1'b0, 1'b1, 1'b0, 16'h0000, 4'h0, 7'h24, 1'b0, 4'hB};

    // Fixed vector table from reset through the first digits of 0x1234
    for (int i = 0; i < 13; i++) begin
      step(vt[i].r, vt[i].en, vt[i].ld, vt[i].di, vt[i].dpi, $sformatf("vec%0d_model", i));
      check_const(vt[i].seg, vt[i].dp, vt[i].an, $sformatf("vec%0d", i));
    end

    // Full scan of 0x1234 and of 0xABCD
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 16'h0000, 4'h0, "scan1234");
    step(1'b0, 1'b1, 1'b1, 16'hABCD, 4'h0, "loadABCD");
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 16'h0000, 4'h0, "scanABCD");

    // All 16 nibble values on digit 0
    for (int v = 0; v < 16; v++) begin
      step(1'b1, 1'b0, 1'b0, 16'h0000, 4'h0, "nib_rst");
      step(1'b0, 1'b0, 1'b1, 16'(v), 4'h1, "nib_load");
      step(1'b0, 1'b1, 1'b0, 16'h0000, 4'h0, $sformatf("nib%0d", v));
      check_const(~dec_tab[v], 1'b0, 4'hE, $sformatf("nib%0d_const", v));
    end

    // Load coincident with the digit1->digit2 transition
    step(1'b1, 1'b0, 1'b0, 16'h0000, 4'h0, "tick_rst");
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, 16'h0000, 4'h0, "tick_pre");
    step(1'b0, 1'b1, 1'b1, 16'h5A3C, 4'h4, "tick_load");
    step(1'b0, 1'b1, 1'b0, 16'h0000, 4'h0, "tick_new");
    check_const(7'h08, 1'b0, 4'hB, "tick_new_const");

    // Disable mid digit2 for 10 cycles, then resume
    step(1'b0, 1'b1, 1'b0, 16'h0000, 4'h0, "mid2");
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 16'h0000, 4'h0, "disabled");
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 16'h0000, 4'h0, "resume");

    // Leading-zero data
    step(1'b0, 1'b1, 1'b1, 16'h0040, 4'h0, "load0040");
    for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 1'b0, 16'h0000, 4'h0, "scan0040");
    step(1'b0, 1'b1, 1'b1, 16'h0000, 4'h0, "load0000");
    for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 1'b0, 16'h0000, 4'h0, "scan0000");

    // Mid-scan reset then restart
    step(1'b1, 1'b1, 1'b0, 16'h0000, 4'h0, "midrst");
    step(1'b0, 1'b1, 1'b0, 16'h0000, 4'h0, "after_rst");
    check_const(7'h40, 1'b1, 4'hE, "after_rst_const");

    // Random stimulus
    for (int i = 0; i < 400; i++) begin
      logic r, en, ld;
      logic [15:0] di;
      r  = ($urandom_range(0, 49) == 0);
      en = ($urandom_range(0, 9) != 0);
      ld = ($urandom_range(0, 7) == 0);
      di = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 4)));
      step(r, en, ld, di, 4'($urandom), "random");
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
